// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding, beat size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam int unsigned BEAT_BYTES = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signals of the arbiter; master = arbiter view, slave = environment view.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, grant
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, grant
  );
endinterface

// File: rtl/mem_arb_burst_ctr.sv
// Beat counter for one line burst; wraps to 0 after the last beat, last_o flags beat BURST_LEN-1.
module mem_arb_burst_ctr #(
  parameter int BURST_LEN = 4,
  parameter int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [BW-1:0] beat_o,
  output logic          last_o
);
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;

  assign beat_o = beat_q;
  assign last_o = (beat_q == BW'(BURST_LEN - 1));

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = last_o ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-refill and D-refill/writeback: 1-cycle grant, one aligned burst, beats stall on mem_ready.
// Default arbitration is fixed D-over-I; define MEM_ARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic      clk,
  input logic      reset,
  mem_arb_if.master bus
);
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W = $clog2(BURST_LEN) + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  state_e            state_q;
  owner_e            grant_q;
  owner_e            win;
  logic              we_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] base_q;
  logic [BW-1:0]     beat;
  logic              last_beat;
  logic              beat_done;
  logic              own_i;
  logic              own_d;
`ifdef MEM_ARB_RR_EN
  owner_e            last_q;
`endif

  // mem_req_q is high exactly while in BURST, so it doubles as the state qualifier.
  assign beat_done = mem_req_q & bus.mem_ready;

  mem_arb_burst_ctr #(.BURST_LEN(BURST_LEN)) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (~mem_req_q),
    .adv_i  (beat_done),
    .beat_o (beat),
    .last_o (last_beat)
  );

  always_comb begin
    win = OWN_NONE;
    if (bus.d_req && bus.i_req) begin
`ifdef MEM_ARB_RR_EN
      win = (last_q == OWN_D) ? OWN_I : OWN_D;
`else
      win = OWN_D;
`endif
    end else if (bus.d_req) begin
      win = OWN_D;
    end else if (bus.i_req) begin
      win = OWN_I;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= OWN_NONE;
      we_q      <= 1'b0;
      mem_req_q <= 1'b0;
      base_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= OWN_I;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win != OWN_NONE) begin
            grant_q   <= win;
            we_q      <= (win == OWN_D) && bus.d_we;
            base_q    <= ((win == OWN_D) ? bus.d_addr : bus.i_addr) & LINE_MASK;
            mem_req_q <= 1'b1;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (beat_done && last_beat) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          grant_q <= OWN_NONE;
`ifdef MEM_ARB_RR_EN
          last_q  <= grant_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign own_i = (grant_q == OWN_I);
  assign own_d = (grant_q == OWN_D);

  assign bus.grant     = grant_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_req_q & we_q;
  assign bus.mem_addr  = mem_req_q ? base_q + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES) : '0;
  assign bus.mem_wdata = (mem_req_q & we_q) ? bus.d_wdata : '0;

  assign bus.i_rvalid = beat_done & ~we_q & own_i;
  assign bus.d_rvalid = beat_done & ~we_q & own_d;
  assign bus.d_wready = beat_done & we_q & own_d;
  assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
  assign bus.i_done   = (state_q == DONE) & own_i;
  assign bus.d_done   = (state_q == DONE) & own_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected beats/dones, a negedge monitor checks them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   widx   = 0;
  int   cyc;
  int   seen;
  logic adv;
  logic rdy_pat[$];
  beat_t exp_beats[$];
  logic [1:0] exp_done[$];
  beat_t e;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  // Memory model: read data is the beat address tagged with 0xCAFE in the top half.
  assign bus.mem_rdata  = bus.mem_addr ^ 32'hCAFE_0000;
  assign bus1.mem_rdata = bus1.mem_addr ^ 32'hCAFE_0000;

  mem_arbiter #(.BURST_LEN(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_arbiter #(.BURST_LEN(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    n_chk++;
    $display("FAIL %s: event seen with nothing expected", name);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_read(input logic [1:0] own, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.own  = own;
      b.we   = 1'b0;
      b.addr = base + 32'(4 * k);
      b.dat  = (base + 32'(4 * k)) ^ 32'hCAFE_0000;
      exp_beats.push_back(b);
    end
    exp_done.push_back(own);
  endtask

  task automatic push_write(input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.own  = OWN_D;
      b.we   = 1'b1;
      b.addr = base + 32'(4 * k);
      b.dat  = 32'hD000_0000 + 32'(k);
      exp_beats.push_back(b);
    end
    exp_done.push_back(OWN_D);
  endtask

  // Counts cycles from the grant cycle (cycle 1) until a done pulse is visible.
  task automatic wait_done(output int c);
    c = 1;
    while (!(bus.i_done || bus.d_done) && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic drop_req(input logic [1:0] own);
    if (own == OWN_I) bus.i_req = 1'b0;
    else bus.d_req = 1'b0;
  endtask

  task automatic pair_test(input string tag, input logic [1:0] first,
                           input logic [31:0] ia, input logic [31:0] da);
    logic [1:0] second;
    second = (first == OWN_I) ? OWN_D : OWN_I;
    bus.i_addr = ia;
    bus.d_addr = da;
    bus.d_we   = 1'b0;
    push_read(first,  (first == OWN_I) ? (ia & 32'hFFFF_FFF0) : (da & 32'hFFFF_FFF0));
    push_read(second, (second == OWN_I) ? (ia & 32'hFFFF_FFF0) : (da & 32'hFFFF_FFF0));
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    tick();
    check({tag, "_first_grant"}, 32'(bus.grant), 32'(first));
    wait_done(cyc);
    check({tag, "_first_done_cycle"}, cyc, 5);
    tick();
    drop_req(first);
    check({tag, "_gap_grant"}, 32'(bus.grant), 0);
    tick();
    check({tag, "_second_grant"}, 32'(bus.grant), 32'(second));
    wait_done(cyc);
    check({tag, "_second_done_cycle"}, cyc, 5);
    tick();
    drop_req(second);
    check({tag, "_drained"}, exp_beats.size() + exp_done.size(), 0);
  endtask

  // Monitor: compares each completed beat and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ready) begin
        if (exp_beats.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          e = exp_beats.pop_front();
          check("beat_addr", bus.mem_addr, e.addr);
          check("beat_we", 32'(bus.mem_we), 32'(e.we));
          check("beat_grant", 32'(bus.grant), 32'(e.own));
          if (e.we) begin
            check("d_wready", 32'(bus.d_wready), 1);
            check("mem_wdata", bus.mem_wdata, e.dat);
            check("i_quiet", 32'({bus.i_rvalid, bus.i_done}) | bus.i_rdata, 0);
          end else if (e.own == OWN_I) begin
            check("i_rvalid", 32'(bus.i_rvalid), 1);
            check("i_rdata", bus.i_rdata, e.dat);
            check("d_quiet", 32'({bus.d_rvalid, bus.d_wready}) | bus.d_rdata, 0);
          end else begin
            check("d_rvalid", 32'(bus.d_rvalid), 1);
            check("d_rdata", bus.d_rdata, e.dat);
            check("i_quiet", 32'(bus.i_rvalid) | bus.i_rdata, 0);
          end
        end
      end else if (bus.i_rvalid || bus.d_rvalid || bus.d_wready) begin
        fail("stray_strobe");
      end
      if (bus.i_done || bus.d_done) begin
        if (exp_done.size() == 0) fail("unexpected_done");
        else check("done_owner", 32'({bus.d_done, bus.i_done}), 32'(exp_done.pop_front()));
      end
    end
  end

  // Memory-ready pattern and writeback data source (data advances after each d_wready).
  initial begin
    forever begin
      @(negedge clk);
      adv = bus.d_wready;
      @(posedge clk);
      #1;
      if (adv) widx++;
      bus.d_wdata = 32'hD000_0000 + 32'(widx);
      if (bus.mem_req && rdy_pat.size() > 0) bus.mem_ready = rdy_pat.pop_front();
      else bus.mem_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req  = 1'b0; bus.i_addr = '0;
    bus.d_req  = 1'b0; bus.d_we   = 1'b0; bus.d_addr = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0;
    bus1.d_req = 1'b0; bus1.d_we   = 1'b0; bus1.d_addr = '0;
    bus1.d_wdata = '0; bus1.mem_ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_mem_req", 32'({bus.mem_req, bus.mem_we}), 0);
    check("rst_mem_addr", bus.mem_addr | bus.mem_wdata, 0);
    check("rst_strobes", 32'({bus.i_done, bus.d_done, bus.i_rvalid, bus.d_rvalid, bus.d_wready}), 0);
    reset = 1'b0;
    tick();

    // I refill alone from an unaligned address
    bus.i_addr = 32'h0000_1234;
    push_read(OWN_I, 32'h0000_1230);
    bus.i_req = 1'b1;
    tick();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_addr0", bus.mem_addr, 32'h0000_1230);
    wait_done(cyc);
    check("t1_done_cycle", cyc, 5);
    tick();
    bus.i_req = 1'b0;
    check("t1_done_pulse", 32'(bus.i_done), 0);
    check("t1_drained", exp_beats.size() + exp_done.size(), 0);

    // D writeback with memory wait states
    widx = 0;
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.d_addr = 32'h0000_2000;
    bus.d_we   = 1'b1;
    push_write(32'h0000_2000);
    bus.d_req = 1'b1;
    tick();
    check("t2_grant", 32'(bus.grant), 32'h2);
    check("t2_mem_we", 32'(bus.mem_we), 1);
    wait_done(cyc);
    check("t2_done_cycle", cyc, 7);
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    check("t2_drained", exp_beats.size() + exp_done.size(), 0);

    // Simultaneous requests; last owner is D here
`ifdef MEM_ARB_RR_EN
    pair_test("t3", OWN_I, 32'h0000_4008, 32'h0000_3000);
`else
    pair_test("t3", OWN_D, 32'h0000_4008, 32'h0000_3000);
`endif

    // Lone I burst leaves last owner = I, so the next pair goes to D in either mode
    bus.i_addr = 32'h0000_5000;
    push_read(OWN_I, 32'h0000_5000);
    bus.i_req = 1'b1;
    tick();
    wait_done(cyc);
    check("t4_lone_done_cycle", cyc, 5);
    tick();
    bus.i_req = 1'b0;
    pair_test("t4", OWN_D, 32'h0000_6004, 32'h0000_7000);

    // Reset during beat 2 of an I burst
    bus.i_addr = 32'h0000_1234;
    push_read(OWN_I, 32'h0000_1230);
    bus.i_req = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check("t5_rst_mem_req", 32'(bus.mem_req), 0);
    check("t5_rst_grant", 32'(bus.grant), 0);
    check("t5_beats_before_rst", exp_beats.size(), 2);
    exp_beats.delete();
    exp_done.delete();
    bus.i_req = 1'b0;
    tick(2);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.i_done || bus.d_done) seen++;
    end
    check("t5_no_done", seen, 0);
    push_read(OWN_I, 32'h0000_1230);
    bus.i_req = 1'b1;
    tick();
    check("t5_restart_addr", bus.mem_addr, 32'h0000_1230);
    wait_done(cyc);
    check("t5_restart_done_cycle", cyc, 5);
    tick();
    bus.i_req = 1'b0;
    check("t5_drained", exp_beats.size() + exp_done.size(), 0);

    // Single-beat burst instance
    bus1.d_addr = 32'h0000_0040;
    bus1.d_we   = 1'b0;
    bus1.d_req  = 1'b1;
    tick();
    check("t6_grant", 32'(bus1.grant), 32'h2);
    check("t6_mem_addr", bus1.mem_addr, 32'h0000_0040);
    check("t6_d_rvalid", 32'(bus1.d_rvalid), 1);
    check("t6_d_rdata", bus1.d_rdata, 32'hCAFE_0040);
    tick();
    check("t6_d_done", 32'(bus1.d_done), 1);
    check("t6_mem_req_off", 32'({bus1.mem_req, bus1.d_rvalid}), 0);
    tick();
    bus1.d_req = 1'b0;
    check("t6_done_pulse", 32'({bus1.d_done, bus1.grant}), 0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between I-cache line refill and D-cache line refill/writeback.
- Sits below both caches, which drive Ihit/Dhit into the pipeline; the pipeline stalls until the owning cache sees its done pulse.
- Requests are arbitrated, the winner gets one line-aligned fixed-length burst, and read beats are routed back to the owner.

Parameters:
- BURST_LEN, 4: beats per line burst; power of two, at least 1.
- ADDR_W, 32: address width.
- DATA_W, 32: beat width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  I-cache burst request; held high until i_done.
- i_addr  in  ADDR_W  I-cache miss address (any alignment).
- i_rdata  out  DATA_W  read beat to the I-cache.
- i_rvalid  out  1  i_rdata valid this cycle.
- i_done  out  1  one-cycle pulse: I burst complete.
- d_req  in  1  D-cache burst request; held high until d_done.
- d_we  in  1  1 = writeback burst, 0 = refill burst; sampled at grant.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  DATA_W  writeback beat; advances on d_wready.
- d_wready  out  1  d_wdata consumed this cycle.
- d_rdata  out  DATA_W  read beat to the D-cache.
- d_rvalid  out  1  d_rdata valid this cycle.
- d_done  out  1  one-cycle pulse: D burst complete.
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  DATA_W  write beat.
- mem_ready  in  1  memory accepts/returns the beat this cycle.
- mem_rdata  in  DATA_W  read beat, valid when mem_ready and ~mem_we.
- grant  out  2  owner: 00 none, 01 I, 10 D.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, grant=00, beat counter 0, last-owner = I. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, done/rvalid/wready. A reset mid-burst abandons the burst; no done pulse is issued.
- State IDLE:
  - No request: stay in IDLE.
  - Any request: select winner (see priority) and latch base = addr with low log2(BURST_LEN)+2 bits cleared.
  - Latch we: d_we for D, 0 for I.
  - Set grant and go to BURST next cycle. Grant latency is 1 cycle from req sampled high.
- State BURST:
  - mem_req=1, mem_we=latched we, mem_addr = base + 4*beat.
  - mem_wdata = d_wdata (D-writeback only, else 0).
  - A beat completes only in a cycle with mem_ready=1. Waits of any length are legal; all outputs hold while mem_ready=0.
  - On a completed read beat: owner rdata = mem_rdata and owner rvalid=1, combinationally in the same cycle.
  - On a completed write beat: d_wready=1.
  - beat increments on each completed beat. On completion of beat BURST_LEN-1, go to DONE; beat resets to 0.
- State DONE:
  - mem_req=0, owner done=1 for exactly this cycle, update last-owner, go to IDLE.
  - The requester drops req on the cycle after done. A req still high in IDLE is a new request.
- Priority when both requests are high in IDLE: D wins (fixed), unless ARB_RR_EN.
- Request drop mid-burst is ignored; the burst always runs to completion. Changes to addr/d_we after grant are ignored.
- The non-owner's rvalid, wready and done are always 0. Non-owner rdata is 0.
- Beat counter width is max(1, log2(BURST_LEN)). Address arithmetic wraps modulo 2^ADDR_W and never crosses the aligned line.
- BURST_LEN=1: single beat; BURST goes to DONE on the first mem_ready.
- Minimum turnaround between back-to-back bursts: 2 idle memory cycles (DONE, IDLE).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the requester that is not last-owner. A lone request is granted regardless.
- Undefined: fixed priority, D always wins. I may wait for consecutive D bursts; this is accepted because D requests are bounded by the pipeline stall.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BURST, DONE}.
  - owner enum {OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10}.
  - BEAT_BYTES=4 constant.
- One sub-module, mem_arb_burst_ctr: beat counter with clear, advance (mem_ready & BURST) and last-beat flag. Parameterised by BURST_LEN.

Test Plan:
- I refill alone, i_addr=0x0000_1234, mem_ready always 1 → grant=01 next cycle; mem_addr 0x1230,0x1234,0x1238,0x123C; four i_rvalid pulses carrying mem_rdata; i_done pulses in the cycle after the fourth beat.
- D writeback, d_addr=0x2000, d_we=1, mem_ready pattern 1,0,1,1,0,1 → mem_we=1; exactly 4 d_wready pulses aligned to mem_ready; d_done after the 4th accepted beat; i_* outputs stay 0.
- i_req and d_req rise together, fixed priority → D burst first (grant=10), then I (grant=01) starts 2 cycles after d_done.
- Same as previous with MEM_ARB_RR_EN defined, last-owner=D → I granted first. A second simultaneous pair → D granted.
- Assert reset during beat 2 of an I burst → mem_req=0 and grant=00 immediately; no i_done. After release, a new i_req restarts at beat 0.
- BURST_LEN=1, d_we=0, d_addr=0x40 → one beat at 0x40; d_rvalid=1 once; d_done in the next cycle.
